// File: rtl/sqrt_dispatch.sv
// sqrt_dispatch: operand FIFO feeding a START/AVAILABLE/DONE square-root engine,
// returning results on a valid/ready port with a watchdog that turns a hung engine into an error result.
module sqrt_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_timeout,
  output logic [31:0] eng_in,
  output logic        eng_start,
  input  logic [31:0] eng_out,
  input  logic        eng_done,
  input  logic        eng_available,
  output logic        busy,
  output logic [7:0]  timeout_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, RELEASE = 2'd2;
  localparam logic [7:0] WD_MAX = 8'(TIMEOUT), WD_EXP = 8'(TIMEOUT - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic s_ready_q, s_ready_d;
  logic [1:0] state_q, state_d;
  logic [7:0] wd_q, wd_d, tcnt_q, tcnt_d;
  logic [31:0] eng_in_q, eng_in_d, m_data_q, m_data_d;
  logic eng_start_q, eng_start_d, m_valid_q, m_valid_d, m_timeout_q, m_timeout_d;
  logic push, pop, slot_free, done_ld, to_ld, load;
  always_comb begin
    push        = s_valid && s_ready_q;
    pop         = (state_q == IDLE) && (cnt_q != '0) && eng_available;
    slot_free   = !m_valid_q || m_ready;
    done_ld     = (state_q == RUN) && eng_done && slot_free;
    // a completing engine always beats an expiring watchdog in the same cycle
    to_ld       = (state_q == RUN) && !eng_done && (wd_q >= WD_EXP) && slot_free;
    load        = done_ld || to_ld;
    wr_d        = push ? wr_q + 1'b1 : wr_q;
    rd_d        = pop ? rd_q + 1'b1 : rd_q;
    cnt_d       = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    s_ready_d   = cnt_d != FULL;
    state_d     = (state_q == IDLE) ? (pop ? RUN : IDLE) :
                  (state_q == RUN) ? (load ? RELEASE : RUN) :
                  (state_q == RELEASE) ? ((!eng_done && eng_available) ? IDLE : RELEASE) : IDLE;
    eng_start_d = pop ? 1'b1 : (load ? 1'b0 : eng_start_q);
    eng_in_d    = pop ? mem_q[rd_q] : eng_in_q;
    wd_d        = pop ? 8'd0 : ((state_q == RUN) && (wd_q != WD_MAX)) ? wd_q + 8'd1 : wd_q;
    m_valid_d   = load || (m_valid_q && !m_ready);
    m_data_d    = done_ld ? eng_out : (to_ld ? 32'hFFFF_FFFF : m_data_q);
    m_timeout_d = load ? to_ld : m_timeout_q;
    tcnt_d      = (to_ld && (tcnt_q != 8'hFF)) ? tcnt_q + 8'd1 : tcnt_q;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= s_data;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      s_ready_q   <= 1'b1;
      state_q     <= IDLE;
      wd_q        <= '0;
      tcnt_q      <= '0;
      eng_in_q    <= '0;
      eng_start_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_timeout_q <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      s_ready_q   <= s_ready_d;
      state_q     <= state_d;
      wd_q        <= wd_d;
      tcnt_q      <= tcnt_d;
      eng_in_q    <= eng_in_d;
      eng_start_q <= eng_start_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_timeout_q <= m_timeout_d;
    end
  end
  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_timeout   = m_timeout_q;
  assign eng_in      = eng_in_q;
  assign eng_start   = eng_start_q;
  assign busy        = (state_q != IDLE) || (cnt_q != '0);
  assign timeout_cnt = tcnt_q;
endmodule

// File: tb/tb_sqrt_dispatch.sv
// tb_sqrt_dispatch: random and directed stimulus against a behavioural engine model,
// with a queue scoreboard checked by an independent output monitor.
module tb_sqrt_dispatch;
  localparam int DEPTH = 4, TIMEOUT = 64;
  logic clk = 0, rstn = 0;
  logic s_valid = 0, s_ready, m_valid, m_ready = 0, m_timeout, eng_start, eng_done, eng_available, busy;
  logic [31:0] s_data = 0, m_data, eng_in, eng_out;
  logic [7:0] timeout_cnt;
  always #5 clk = ~clk;
  sqrt_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_timeout(m_timeout),
    .eng_in(eng_in), .eng_start(eng_start), .eng_out(eng_out), .eng_done(eng_done),
    .eng_available(eng_available), .busy(busy), .timeout_cnt(timeout_cnt));
  function automatic logic [31:0] isqrt(input logic [31:0] x);
    longint r = 0, t;
    for (int b = 15; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return r[31:0];
  endfunction
  // engine model: idle -> busy for lat cycles -> done held until start drops; aborts if start drops early
  logic e_busy = 0, e_done = 0, hang = 0;
  logic [31:0] e_op = 0, e_res = 0;
  int e_cnt = 0, fixed_lat = -1;
  assign eng_done = e_done;
  assign eng_out = e_res;
  assign eng_available = !e_busy;
  always @(posedge clk) begin
    if (!e_busy) begin
      if (eng_start) begin
        e_busy <= 1;
        e_op <= eng_in;
        e_cnt <= (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 30));
      end
    end else if (e_done) begin
      if (!eng_start) begin
        e_done <= 0;
        e_busy <= 0;
      end
    end else if (!eng_start) e_busy <= 0;
    else if (!hang && e_cnt == 0) begin
      e_done <= 1;
      e_res <= isqrt(e_op);
    end else if (e_cnt > 0) e_cnt <= e_cnt - 1;
  end
  typedef struct packed {logic to; logic [31:0] d;} exp_t;
  exp_t sb[$];
  exp_t e_m;
  int n_vec = 0, n_bad = 0, acc = 0, starts = 0;
  longint cyc = 0, start_cyc = 0;
  logic pv = 0, pr = 0, ps = 0, pd = 0, pfree = 0, pto = 0, saw_full = 0, rnd_ready = 0;
  logic [31:0] pdata = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    if (!rstn) begin
      pv = 0;
      ps = 0;
      pd = 0;
    end else begin
      if (eng_start && !ps) begin
        starts++;
        start_cyc = cyc;
      end
      if (!s_ready) saw_full = 1;
      check("s_ready_occupancy", s_ready, (acc - starts) < DEPTH);
      if (pv && !pr) begin
        check("held_valid", m_valid, 1);
        check("held_data", {m_timeout, m_data}, {pto, pdata});
      end
      if (pd && ps && pfree) check("done_to_result", {eng_start, m_valid}, 2'b01);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) check("unexpected_result", {m_timeout, m_data}, 33'h0_dead_beef);
        else begin
          e_m = sb.pop_front();
          check("result", {m_timeout, m_data}, {e_m.to, e_m.d});
        end
      end
      pv = m_valid;
      pr = m_ready;
      ps = eng_start;
      pd = eng_done;
      pfree = !m_valid || m_ready;
      pdata = m_data;
      pto = m_timeout;
    end
  end
  task automatic send(input logic [31:0] x, input logic to, input logic [31:0] exp);
    bit ok = 0;
    #1;
    s_valid = 1;
    s_data = x;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk);
      ok = s_ready;
    end
    if (ok) begin
      acc++;
      sb.push_back({to, exp});
    end else check("send_timeout", 0, 1);
  endtask
  task automatic stop_in();
    #1;
    s_valid = 0;
  endtask
  task automatic set_ready(input logic v);
    @(posedge clk);
    #2;
    m_ready = v;
  endtask
  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = (sb.size() == 0) && !busy && !m_valid;
    end
    check("drain", ok, 1);
  endtask
  task automatic check_reset_vals();
    check("reset_outputs", {s_ready, m_valid, m_timeout, eng_start, busy, m_data, eng_in, timeout_cnt},
          {5'b10000, 32'd0, 32'd0, 8'd0});
  endtask
  initial begin
    bit ok;
    logic [31:0] x;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1 rstn = 1;
    // single operand with exact start timing
    fixed_lat = 4;
    set_ready(1);
    send(16, 0, 4);
    stop_in();
    @(negedge clk);
    check("start_before_dispatch", eng_start, 0);
    @(negedge clk);
    check("start_after_dispatch", {eng_start, eng_in}, {1'b1, 32'd16});
    drain();
    check("busy_idle", busy, 0);
    // burst beyond FIFO depth
    fixed_lat = 10;
    saw_full = 0;
    for (int k = 1; k <= DEPTH + 2; k++) send(k * k, 0, k);
    stop_in();
    drain();
    check("fifo_filled", saw_full, 1);
    // backpressure while engine finishes two operands
    fixed_lat = 3;
    set_ready(0);
    send(25, 0, 5);
    send(36, 0, 6);
    stop_in();
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = eng_done && eng_start && m_valid;
    end
    repeat (5) @(negedge clk);
    check("stalled_second", {ok, eng_start, m_valid, m_data}, {3'b111, 32'd5});
    set_ready(1);
    drain();
    // hung engine: watchdog result at exactly TIMEOUT cycles
    hang = 1;
    send(100, 1, 32'hFFFF_FFFF);
    stop_in();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = eng_start;
    end
    check("hang_started", ok, 1);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = m_valid;
      if (!ok) @(negedge clk);
    end
    check("timeout_latency", cyc - start_cyc, TIMEOUT);
    drain();
    check("timeout_cnt_1", timeout_cnt, 1);
    hang = 0;
    send(49, 0, 7);
    stop_in();
    drain();
    // done on the last watchdog cycle wins; one cycle later loses
    fixed_lat = TIMEOUT - 3;
    send(81, 0, 9);
    stop_in();
    drain();
    check("timeout_cnt_tie", timeout_cnt, 1);
    fixed_lat = TIMEOUT - 2;
    send(64, 1, 32'hFFFF_FFFF);
    stop_in();
    drain();
    check("timeout_cnt_2", timeout_cnt, 2);
    // random traffic with random consumer backpressure
    fixed_lat = -1;
    rnd_ready = 1;
    for (int n = 0; n < 40; n++) begin
      x = $urandom;
      send(x, 0, isqrt(x));
      if ($urandom_range(0, 1) == 1) begin
        stop_in();
        repeat ($urandom_range(1, 3)) @(posedge clk);
      end
    end
    stop_in();
    rnd_ready = 0;
    set_ready(1);
    drain();
    // reset mid-RUN with a held result and three queued operands
    fixed_lat = 2;
    set_ready(0);
    for (int k = 1; k <= 5; k++) send(k, 0, isqrt(k));
    stop_in();
    repeat (10) @(posedge clk);
    #1 rstn = 0;
    sb.delete();
    acc = 0;
    starts = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1 rstn = 1;
    set_ready(1);
    repeat (20) @(negedge clk);
    check("no_stale_after_reset", {m_valid, busy}, 2'b00);
    send(144, 0, 12);
    stop_in();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
